// File: rtl/pyro_fire_sequencer_if.sv
// Control/status bundle between the register bank, pulse detector and the pyro
// fire sequencer. The sequencer is the slave; the controlling side is the master.
interface pyro_fire_sequencer_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 24
);
    localparam int CH_W = $clog2(N_CH);

    logic             arm;
    logic [N_CH-1:0]  fire_req;
    logic [CNT_W-1:0] pulse_width;
    logic [CNT_W-1:0] cooldown;
    logic             det_pulse;
    logic             clear_fault;
    logic [N_CH-1:0]  fire_en;
    logic [N_CH-1:0]  pending;
    logic             busy;
    logic             done_pulse;
    logic             fault;
    logic [CH_W-1:0]  fault_ch;

    modport master (
        output arm, fire_req, pulse_width, cooldown, det_pulse, clear_fault,
        input  fire_en, pending, busy, done_pulse, fault, fault_ch
    );

    modport slave (
        input  arm, fire_req, pulse_width, cooldown, det_pulse, clear_fault,
        output fire_en, pending, busy, done_pulse, fault, fault_ch
    );
endinterface

// File: rtl/pyro_fire_sequencer.sv
// Round-robin scheduler of squib firing shots onto one shared firing driver,
// with detector confirmation, mandatory cooldown and a sticky no-current fault.
module pyro_fire_sequencer #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 24
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    pyro_fire_sequencer_if.slave bus
);
    localparam int CH_W = $clog2(N_CH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [N_CH-1:0]  CH_NONE  = {N_CH{1'b0}};
    localparam logic [N_CH-1:0]  CH_ONE   = {{(N_CH-1){1'b0}}, 1'b1};
    localparam logic [CH_W-1:0]  IDX_ZERO = {CH_W{1'b0}};
    localparam logic [CH_W:0]    IDX_INC  = {{CH_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRE  = 2'd1,
        ST_COOL  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [N_CH-1:0]   req_q_r;
    logic [N_CH-1:0]   pending_r, pending_s;
    logic [N_CH-1:0]   fire_en_r, fire_en_s;
    logic [CH_W-1:0]   ptr_r, ptr_s;
    logic [CH_W-1:0]   fault_ch_r, fault_ch_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              det_seen_r, det_seen_s;
    logic              done_r, done_s;
    logic              fault_r, fault_s;
    logic              busy_r;

    logic [N_CH-1:0]   set_s;
    logic [2*N_CH-1:0] pend2_s;
    logic [N_CH-1:0]   rot_s;
    logic              grant_vld_s;
    logic [CH_W-1:0]   grant_idx_s;
    logic [N_CH-1:0]   grant_oh_s;
    int                off_s;
    logic              last_s;
    logic              det_any_s;

    // Round-robin search: rotate pending so that channel ptr+1 lands at bit 0.
    always_comb begin
        pend2_s     = {pending_r, pending_r} >> ({1'b0, ptr_r} + IDX_INC);
        rot_s       = pend2_s[N_CH-1:0];
        grant_vld_s = |rot_s;
        off_s       = 0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (rot_s[j]) begin
                off_s = j;
            end else begin
                off_s = off_s;
            end
        end
        grant_idx_s = CH_W'((int'(ptr_r) + off_s + 32'sd1) % N_CH);
        grant_oh_s  = CH_ONE << grant_idx_s;
    end

    // Shot sequencing FSM: next state, counters and registered-output values.
    always_comb begin
        set_s      = bus.fire_req & ~req_q_r & {N_CH{bus.arm && (state_r != ST_FAULT)}};
        state_s    = state_r;
        pending_s  = pending_r | set_s;
        fire_en_s  = fire_en_r;
        ptr_s      = ptr_r;
        fault_ch_s = fault_ch_r;
        cnt_s      = cnt_r;
        det_seen_s = det_seen_r;
        done_s     = 1'b0;
        fault_s    = fault_r;
        last_s     = (cnt_r == CNT_ZERO);
        det_any_s  = det_seen_r | bus.det_pulse;

        case (state_r)
            ST_IDLE: begin
                fire_en_s = CH_NONE;
                if (bus.arm && grant_vld_s) begin
                    state_s    = ST_FIRE;
                    fire_en_s  = grant_oh_s;
                    pending_s  = (pending_r & ~grant_oh_s) | set_s;
                    ptr_s      = grant_idx_s;
                    cnt_s      = (bus.pulse_width == CNT_ZERO) ? CNT_ZERO : bus.pulse_width - CNT_ONE;
                    det_seen_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FIRE: begin
                det_seen_s = det_any_s;
                if (!bus.arm || (last_s && det_any_s)) begin
                    // Disarm aborts silently; a confirmed shot reports done.
                    fire_en_s = CH_NONE;
                    done_s    = bus.arm;
                    if (bus.cooldown == CNT_ZERO) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_COOL;
                        cnt_s   = bus.cooldown - CNT_ONE;
                    end
                end else if (last_s) begin
                    fire_en_s  = CH_NONE;
                    state_s    = ST_FAULT;
                    fault_s    = 1'b1;
                    fault_ch_s = ptr_r;
                    pending_s  = set_s;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_COOL: begin
                fire_en_s = CH_NONE;
                if (last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_FAULT: begin
                fire_en_s = CH_NONE;
                pending_s = CH_NONE;
                if (bus.clear_fault) begin
                    state_s    = ST_IDLE;
                    fault_s    = 1'b0;
                    fault_ch_s = IDX_ZERO;
                end else begin
                    state_s = ST_FAULT;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                fire_en_s = CH_NONE;
                pending_s = CH_NONE;
            end
        endcase

        if (!bus.arm) begin
            pending_s = CH_NONE;
        end else begin
            pending_s = pending_s;
        end
    end

    // State and output registers; reset drops fire_en asynchronously.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r    <= ST_IDLE;
            req_q_r    <= CH_NONE;
            pending_r  <= CH_NONE;
            fire_en_r  <= CH_NONE;
            ptr_r      <= IDX_ZERO;
            fault_ch_r <= IDX_ZERO;
            cnt_r      <= CNT_ZERO;
            det_seen_r <= 1'b0;
            done_r     <= 1'b0;
            fault_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            req_q_r    <= bus.fire_req;
            pending_r  <= pending_s;
            fire_en_r  <= fire_en_s;
            ptr_r      <= ptr_s;
            fault_ch_r <= fault_ch_s;
            cnt_r      <= cnt_s;
            det_seen_r <= det_seen_s;
            done_r     <= done_s;
            fault_r    <= fault_s;
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    assign bus.fire_en    = fire_en_r;
    assign bus.pending    = pending_r;
    assign bus.busy       = busy_r;
    assign bus.done_pulse = done_r;
    assign bus.fault      = fault_r;
    assign bus.fault_ch   = fault_ch_r;
endmodule
